// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the N-way write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WB, REFILL, FILLED} state_t;

  localparam int WORD_W = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Way-number width; a single-way cache still needs a 1-bit way index.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set LRU ages: victim selection (lowest invalid way, else oldest) and MRU update.
module dcache_lru
  import dcache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [clog2(SETS)-1:0]     set_i,
  input  logic [WAYS-1:0]            valid_i,
  input  logic                       upd_i,
  input  logic [way_bits(WAYS)-1:0]  upd_way_i,
  output logic [way_bits(WAYS)-1:0]  victim_o
);

  localparam int WAY_W = way_bits(WAYS);

  generate
    if (WAYS > 1) begin : g_lru
      logic [WAY_W-1:0] age_q [SETS][WAYS];
      logic [WAY_W-1:0] best_age;

      always_comb begin
        best_age = age_q[set_i][0];
        victim_o = '0;
        for (int w = 1; w < WAYS; w++) begin
          if (age_q[set_i][w] > best_age) begin
            best_age = age_q[set_i][w];
            victim_o = WAY_W'(w);
          end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
          if (!valid_i[w]) victim_o = WAY_W'(w);
        end
      end

      // Ways no older than the accessed one age by one (saturating); accessed way becomes 0.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              age_q[s][w] <= '0;
        end else if (upd_i) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == upd_way_i)
              age_q[set_i][w] <= '0;
            else if (age_q[set_i][w] <= age_q[set_i][upd_way_i] && age_q[set_i][w] != '1)
              age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
          end
        end
      end
    end else begin : g_single
      assign victim_o = '0;
    end
  endgenerate

endmodule

// File: rtl/dcache_nway_wb.sv
// N-way set-associative write-back, write-allocate data cache with LRU replacement.
module dcache_nway_wb
  import dcache_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);

  localparam int OFS_W  = clog2(LINE_W / 8);
  localparam int IDX_W  = clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFS_W;
  localparam int WAY_W  = way_bits(WAYS);
  localparam int WSEL_W = OFS_W - 2;

  logic [TAG_W-1:0]  tag_q  [WAYS][SETS];
  logic [LINE_W-1:0] line_q [WAYS][SETS];
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];

  state_t            state_q, state_d;
  logic [WAY_W-1:0]  victim_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_wsel;
  logic              req, hit, store_hit, refill_done, lru_upd;
  logic [WAY_W-1:0]  hit_way, lru_victim, upd_way;
  logic [WAYS-1:0]   set_valid;
  logic [LINE_W-1:0] hit_line;
  logic              unused_byte_bits;

  assign req_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx  = p1_addr_i[OFS_W +: IDX_W];
  assign req_wsel = p1_addr_i[OFS_W-1:2];
  assign unused_byte_bits = ^p1_addr_i[1:0];

  assign req = p1_MemRead_i | p1_MemWrite_i;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    set_valid = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid[w] = valid_q[w][req_idx];
      if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line    = line_q[hit_way][req_idx];
  // A request with both strobes high is handled as a store.
  assign store_hit   = (state_q == IDLE) && p1_MemWrite_i && hit;
  assign refill_done = (state_q == REFILL) && mem_ack_i;
  assign lru_upd     = ((state_q == IDLE) && req && hit) || refill_done;
  assign upd_way     = refill_done ? victim_q : hit_way;
  assign p1_data_o   = ((state_q == IDLE) && req && hit) ?
                       hit_line[int'(req_wsel)*WORD_W +: WORD_W] : '0;

  dcache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_i     (req_idx),
    .valid_i   (set_valid),
    .upd_i     (lru_upd),
    .upd_way_i (upd_way),
    .victim_o  (lru_victim)
  );

  always_comb begin
    state_d      = state_q;
    p1_stall_o   = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          p1_stall_o = 1'b1;
          state_d    = dirty_q[lru_victim][req_idx] ? WB : REFILL;
        end
      end
      WB: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[victim_q][req_idx], req_idx, {OFS_W{1'b0}}};
        mem_data_o   = line_q[victim_q][req_idx];
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, req_idx, {OFS_W{1'b0}}};
        if (mem_ack_i) state_d = FILLED;
      end
      FILLED: begin
        // Line is installed; hold the stall one more cycle so the access replays as a hit.
        p1_stall_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && req && !hit) victim_q <= lru_victim;
      if (refill_done) begin
        valid_q[victim_q][req_idx] <= 1'b1;
        dirty_q[victim_q][req_idx] <= 1'b0;
      end
      if (store_hit) dirty_q[hit_way][req_idx] <= 1'b1;
    end
  end

  // Tag and line storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (refill_done) begin
      line_q[victim_q][req_idx] <= mem_data_i;
      tag_q[victim_q][req_idx]  <= req_tag;
    end else if (store_hit) begin
      line_q[hit_way][req_idx][int'(req_wsel)*WORD_W +: WORD_W] <= p1_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_nway_wb.sv
// Directed bench for dcache_nway_wb with a fixed-latency line memory model.
module tb_dcache_nway_wb;

  localparam int LAT        = 10;
  localparam int CLEAN_MISS = 1 + (LAT + 1) + 1;
  localparam int DIRTY_MISS = 1 + 2 * (LAT + 1) + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  p1_addr = '0;
  logic [31:0]  p1_wdata = '0;
  logic         p1_rd = 1'b0;
  logic         p1_wr = 1'b0;
  logic [31:0]  p1_rdata;
  logic         p1_stall;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic [255:0] mem_wdata;
  logic [31:0]  mem_addr;
  logic         mem_en;
  logic         mem_wr;

  int n_tests = 0;
  int n_fail  = 0;

  int           stalls;
  logic         wb_seen, rf_seen;
  logic [31:0]  wb_addr, rf_addr, rdata;
  logic [255:0] wb_line;

  logic [255:0] mem_q [logic [31:0]];
  int           cnt = 0;

  dcache_nway_wb #(.WAYS(2), .SETS(16), .LINE_W(256), .ADDR_W(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .p1_addr_i     (p1_addr),
    .p1_data_i     (p1_wdata),
    .p1_MemRead_i  (p1_rd),
    .p1_MemWrite_i (p1_wr),
    .p1_data_o     (p1_rdata),
    .p1_stall_o    (p1_stall),
    .mem_data_i    (mem_rdata),
    .mem_ack_i     (mem_ack),
    .mem_data_o    (mem_wdata),
    .mem_addr_o    (mem_addr),
    .mem_enable_o  (mem_en),
    .mem_write_o   (mem_wr)
  );

  always #5 clk = ~clk;

  // Untouched lines read as word i = {addr[15:0], 16'hC000 + i}.
  function automatic logic [255:0] init_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {a[15:0], 16'hC000 + 16'(i)};
    return l;
  endfunction

  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (rst || !mem_en) begin
      cnt <= 0;
    end else if (!mem_ack) begin
      if (cnt == LAT - 1) begin
        mem_ack <= 1'b1;
        cnt     <= 0;
        if (mem_wr) mem_q[mem_addr] = mem_wdata;
        else        mem_rdata <= mem_q.exists(mem_addr) ? mem_q[mem_addr] : init_line(mem_addr);
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CPU access held until the stall drops; records memory traffic seen meanwhile.
  task automatic access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd);
    @(negedge clk);
    p1_addr = a; p1_rd = rd; p1_wr = wr; p1_wdata = wd;
    wb_seen = 0; rf_seen = 0; wb_addr = '0; rf_addr = '0; wb_line = '0; stalls = 0;
    #1;
    while (p1_stall && stalls < 200) begin
      if (mem_en && mem_wr)  begin wb_seen = 1; wb_addr = mem_addr; wb_line = mem_wdata; end
      if (mem_en && !mem_wr) begin rf_seen = 1; rf_addr = mem_addr; end
      stalls++;
      @(negedge clk);
      #1;
    end
    chk("stall_released", 256'(p1_stall), 256'(0));
    rdata = p1_rdata;
    @(negedge clk);
    p1_rd = 1'b0; p1_wr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_stall", 256'(p1_stall), 256'(0));
    chk("rst_en",    256'(mem_en),   256'(0));
    chk("rst_wr",    256'(mem_wr),   256'(0));
    chk("rst_addr",  256'(mem_addr), 256'(0));
    chk("rst_wdata", mem_wdata,      256'(0));
    chk("rst_rdata", 256'(p1_rdata), 256'(0));

    // 1: cold load miss
    access(32'h40, 1, 0, 0);
    chk("t1_rf_addr", 256'(rf_addr), 256'(32'h40));
    chk("t1_no_wb",   256'(wb_seen), 256'(0));
    chk("t1_penalty", 256'(stalls),  256'(CLEAN_MISS));
    chk("t1_data",    256'(rdata),   256'(32'h0040_C000));

    // 2: store hit then readback
    access(32'h44, 0, 1, 32'hDEAD_BEEF);
    chk("t2_st_stall", 256'(stalls), 256'(0));
    access(32'h44, 1, 0, 0);
    chk("t2_ld_stall", 256'(stalls), 256'(0));
    chk("t2_ld_data",  256'(rdata),  256'(32'hDEAD_BEEF));
    access(32'h48, 1, 0, 0);
    chk("t2_word2",    256'(rdata),  256'(32'h0040_C002));

    // 3: fill second way, then third tag evicts dirty LRU line
    access(32'h240, 1, 0, 0);
    chk("t3a_no_wb",   256'(wb_seen), 256'(0));
    chk("t3a_penalty", 256'(stalls),  256'(CLEAN_MISS));
    chk("t3a_data",    256'(rdata),   256'(32'h0240_C000));
    access(32'h440, 1, 0, 0);
    chk("t3b_wb_seen", 256'(wb_seen), 256'(1));
    chk("t3b_wb_addr", 256'(wb_addr), 256'(32'h40));
    chk("t3b_wb_w1",   256'(wb_line[63:32]), 256'(32'hDEAD_BEEF));
    chk("t3b_wb_w0",   256'(wb_line[31:0]),  256'(32'h0040_C000));
    chk("t3b_rf_addr", 256'(rf_addr), 256'(32'h440));
    chk("t3b_penalty", 256'(stalls),  256'(DIRTY_MISS));
    chk("t3b_data",    256'(rdata),   256'(32'h0440_C000));

    // 4: touch 0x440 way, miss evicts the other (clean) way, 0x440 retained
    access(32'h44C, 1, 0, 0);
    chk("t4_hit_stall", 256'(stalls), 256'(0));
    chk("t4_hit_data",  256'(rdata),  256'(32'h0440_C003));
    access(32'h40, 1, 0, 0);
    chk("t4_no_wb",     256'(wb_seen), 256'(0));
    chk("t4_rf_addr",   256'(rf_addr), 256'(32'h40));
    chk("t4_penalty",   256'(stalls),  256'(CLEAN_MISS));
    access(32'h44, 1, 0, 0);
    chk("t4_wb_back",   256'(rdata),   256'(32'hDEAD_BEEF));
    access(32'h444, 1, 0, 0);
    chk("t4_keep_stall", 256'(stalls), 256'(0));
    chk("t4_keep_data",  256'(rdata),  256'(32'h0440_C001));
    access(32'h240, 1, 0, 0);
    chk("t4_evicted",    256'(stalls), 256'(CLEAN_MISS));

    // 5: reset during refill wait
    @(negedge clk);
    p1_addr = 32'h1000; p1_rd = 1'b1;
    #1;
    chk("t5_stall", 256'(p1_stall), 256'(1));
    repeat (3) @(negedge clk);
    #1;
    chk("t5_en",   256'(mem_en),   256'(1));
    chk("t5_addr", 256'(mem_addr), 256'(32'h1000));
    @(negedge clk);
    rst = 1'b1; p1_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_en_off",   256'(mem_en),   256'(0));
    chk("t5_stall_off", 256'(p1_stall), 256'(0));
    access(32'h444, 1, 0, 0);
    chk("t5_invalid", 256'(stalls), 256'(CLEAN_MISS));
    access(32'h40, 1, 0, 0);
    chk("t5_no_wb",   256'(wb_seen), 256'(0));

    // 6: read+write together acts as store; idle bus shows no traffic
    access(32'h448, 1, 1, 32'h1234_5678);
    chk("t6_rw_stall", 256'(stalls), 256'(0));
    access(32'h448, 1, 0, 0);
    chk("t6_rw_data",  256'(rdata),  256'(32'h1234_5678));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      p1_addr = $urandom; p1_wdata = $urandom; p1_rd = 1'b0; p1_wr = 1'b0;
      #1;
      chk("t6_idle_en",    256'(mem_en),   256'(0));
      chk("t6_idle_stall", 256'(p1_stall), 256'(0));
    end
    access(32'h44C, 1, 0, 0);
    chk("t6_after_idle", 256'(stalls), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
